// File: rtl/vga_timing_pkg.sv
// Default VGA raster timing (800x600 @ 60 Hz, 40 MHz pixel clock) and the
// coordinate type shared by the sync generator and the draw stages.
package vga_timing_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 11;
    localparam int COORD_MAX_TOTAL = 2048;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/raster_counter.sv
// Wrap counter 0..TOTAL-1 with terminal-count flag. Also exposes the value it
// would take on the next enabled edge so the parent can register decodes of
// that value alongside the count.
module raster_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = H_TOTAL
) (
    input  logic   pclk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output coord_t count_next,
    output logic   tc
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    assign tc         = (count == LAST);
    assign count_next = tc ? '0 : count + coord_t'(1);

    // Advance one step per enabled edge, wrapping at TOTAL-1.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster position and sync/blank generator; head of the video chain.
// hs/vs/hblnk/vblnk are decoded from the counters' next values and registered
// on the same edge as the counters, so every output describes the same pixel.
// Optional feature macro: VGA_FRAME_CNT_EN adds the frame_cnt output.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    output coord_t      hcount,
    output coord_t      vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        hs,
`ifdef VGA_FRAME_CNT_EN
    output logic        vs,
    output logic [15:0] frame_cnt
`else
    output logic        vs
`endif
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (HT > COORD_MAX_TOTAL) begin : g_h_total_too_big
        $error("vga_sync_gen: horizontal total exceeds 11-bit counter range");
    end
    if (VT > COORD_MAX_TOTAL) begin : g_v_total_too_big
        $error("vga_sync_gen: vertical total exceeds 11-bit counter range");
    end

    localparam coord_t H_BLNK_START = coord_t'(H_ACTIVE);
    localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t V_BLNK_START = coord_t'(V_ACTIVE);
    localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t h_next;
    coord_t v_step;
    coord_t v_next;
    logic   h_tc;
    logic   v_tc;
    logic   v_en;

    assign v_en = en & h_tc;

    raster_counter #(.TOTAL(HT)) u_h_cnt (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .en         (en),
        .count      (hcount),
        .count_next (h_next),
        .tc         (h_tc)
    );

    raster_counter #(.TOTAL(VT)) u_v_cnt (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .en         (v_en),
        .count      (vcount),
        .count_next (v_step),
        .tc         (v_tc)
    );

    // Line only changes on the horizontal wrap edge.
    assign v_next = h_tc ? v_step : vcount;

    // Register sync and blank decodes of the position being entered.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hblnk <= 1'b0;
            vblnk <= 1'b0;
            hs    <= ~HS_POL;
            vs    <= ~VS_POL;
        end else if (en) begin
            hblnk <= (h_next >= H_BLNK_START);
            vblnk <= (v_next >= V_BLNK_START);
            hs    <= ((h_next >= H_SYNC_START) && (h_next < H_SYNC_END)) ? HS_POL : ~HS_POL;
            vs    <= ((v_next >= V_SYNC_START) && (v_next < V_SYNC_END)) ? VS_POL : ~VS_POL;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Count completed frames; wraps naturally at 16 bits.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (v_en && v_tc) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance, inverted-polarity instance
// and a small-timing instance (so whole frames fit in a short run), all checked
// against a linear pixel-index model of the raster.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    always #5 pclk = ~pclk;

    coord_t a_h, a_v, b_h, b_v, c_h, c_v;
    logic a_hb, a_vb, a_hs, a_vs;
    logic b_hb, b_vb, b_hs, b_vs;
    logic c_hb, c_vb, c_hs, c_vs;
    logic [15:0] a_fc, b_fc, c_fc;

    int n_cmp = 0;
    int n_bad = 0;
    longint idx = 0;   // pixels advanced since last reset

    vga_sync_gen u_dut_a (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount(a_h), .vcount(a_v), .hblnk(a_hb), .vblnk(a_vb),
`ifdef VGA_FRAME_CNT_EN
        .hs(a_hs), .vs(a_vs), .frame_cnt(a_fc)
`else
        .hs(a_hs), .vs(a_vs)
`endif
    );

    vga_sync_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) u_dut_b (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount(b_h), .vcount(b_v), .hblnk(b_hb), .vblnk(b_vb),
`ifdef VGA_FRAME_CNT_EN
        .hs(b_hs), .vs(b_vs), .frame_cnt(b_fc)
`else
        .hs(b_hs), .vs(b_vs)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_dut_c (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount(c_h), .vcount(c_v), .hblnk(c_hb), .vblnk(c_vb),
`ifdef VGA_FRAME_CNT_EN
        .hs(c_hs), .vs(c_vs), .frame_cnt(c_fc)
`else
        .hs(c_hs), .vs(c_vs)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign a_fc = '0;
    assign b_fc = '0;
    assign c_fc = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t idx=%0d: got %0h expected %0h", tag, $time, idx, obs, exp);
        end
    endtask

    // Expected outputs from the pixel index and the timing of one instance.
    task automatic chk_inst(input string nm,
                            input int ha, input int hf, input int hsy, input int hb,
                            input int va, input int vf, input int vsy, input int vb,
                            input bit hp, input bit vp,
                            input coord_t oh, input coord_t ov,
                            input logic ohb, input logic ovb,
                            input logic ohs, input logic ovs,
                            input logic [15:0] ofc);
        longint ht, vt, h, v, f;
        bit hs_on, vs_on;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        h  = idx % ht;
        v  = (idx / ht) % vt;
        f  = (idx / (ht * vt)) % 65536;
        hs_on = (h >= ha + hf) && (h < ha + hf + hsy);
        vs_on = (v >= va + vf) && (v < va + vf + vsy);
        chk({nm, ".hcount"}, 32'(oh), 32'(h));
        chk({nm, ".vcount"}, 32'(ov), 32'(v));
        chk({nm, ".hblnk"},  32'(ohb), 32'(h >= ha));
        chk({nm, ".vblnk"},  32'(ovb), 32'(v >= va));
        chk({nm, ".hs"},     32'(ohs), 32'(hs_on ? hp : !hp));
        chk({nm, ".vs"},     32'(ovs), 32'(vs_on ? vp : !vp));
`ifdef VGA_FRAME_CNT_EN
        chk({nm, ".frame_cnt"}, 32'(ofc), 32'(f));
`else
        if (ofc !== 16'h0) chk({nm, ".frame_cnt_absent"}, 32'(ofc), 32'h0);
`endif
    endtask

    task automatic chk_all();
        chk_inst("a", 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1,
                 a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_fc);
        chk_inst("b", 800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0,
                 b_h, b_v, b_hb, b_vb, b_hs, b_vs, b_fc);
        chk_inst("c", 8, 2, 3, 3, 6, 1, 2, 2, 1'b1, 1'b1,
                 c_h, c_v, c_hb, c_vb, c_hs, c_vs, c_fc);
    endtask

    // One clock with the given enable; inputs change 1ns after the edge.
    task automatic step(input logic e);
        en = e;
        @(posedge pclk);
        if (e && rst_n) idx++;
        #1;
        chk_all();
    endtask

    initial begin
        int guard;
        // Reset held, en high must not move anything.
        en = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk_all();
        #2 rst_n = 1'b1;
        #1;
        chk_all();

        // One full default line and into the next.
        for (int i = 0; i < 1056 + 20; i++) step(1'b1);
        chk("a.line_wrap_v", 32'(a_v), 32'd1);

        // Random enable pattern.
        for (int i = 0; i < 3000; i++) step(1'(($urandom_range(0, 3)) != 0));

        // Park at column 839, hold for 50 cycles, then step into hsync.
        guard = 0;
        while ((idx % 1056) != 839 && guard < 2000) begin
            step(1'b1);
            guard++;
        end
        chk("a.reach_839", 32'(a_h), 32'd839);
        for (int i = 0; i < 50; i++) step(1'b0);
        chk("a.frozen_h", 32'(a_h), 32'd839);
        step(1'b1);
        chk("a.hs_at_840", 32'(a_hs), 32'd1);
        chk("b.hs_at_840", 32'(b_hs), 32'd0);

        // Reset mid-line at column 900: outputs clear before the next edge.
        guard = 0;
        while ((idx % 1056) != 900 && guard < 2000) begin
            step(1'b1);
            guard++;
        end
        chk("a.hs_before_rst", 32'(a_hs), 32'd1);
        #2 rst_n = 1'b0;
        idx = 0;
        #1;
        chk("a.hs_async_rst", 32'(a_hs), 32'd0);
        chk("a.h_async_rst",  32'(a_h),  32'd0);
        chk_all();
        @(negedge pclk);
        rst_n = 1'b1;
        #1;
        chk_all();

        // Long random run; small instance crosses many frame boundaries.
        for (int i = 0; i < 6000; i++) step(1'(($urandom_range(0, 4)) != 0));
        for (int i = 0; i < 400; i++) step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
